// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } imem_state_t;

  localparam logic [31:0] NOP_WORD_DEF    = 32'h0000_0013;
  localparam int          DEPTH_WORDS_DEF = 1024;

  function automatic int idx_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-wide storage: asynchronous read, synchronous write, no reset (distributed-RAM friendly).
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: zero-latency fetch port plus a streaming word loader
// that holds the core while it programs the array.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_i_ra,
  output logic [31:0] mem_i_rd,
  output logic        i_fault,
  input  logic        ld_start,
  input  logic [31:0] ld_base,
  input  logic [15:0] ld_len,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        cpu_hold,
  output imem_state_t dbg_state
);

  localparam int AW = idx_width(DEPTH_WORDS);

  // Handshake: a word is written on every rising edge where ld_valid && ld_ready;
  // ld_ready is high only in LOAD, and ld_valid without ld_ready is dropped.
  imem_state_t   state_q;
  logic [AW-1:0] ptr_q;
  logic [15:0]   rem_q;
  logic          ld_done_q, ld_ready_q, cpu_hold_q;
  logic          beat;
  logic          misaligned, out_of_range, bad_fetch;
  logic [31:0]   rdata;
  logic          unused_base;

  assign beat = ld_ready_q && ld_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      ptr_q      <= '0;
      rem_q      <= '0;
      ld_done_q  <= 1'b0;
      ld_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (ld_start) begin
            ptr_q      <= ld_base[AW+1:2];
            rem_q      <= ld_len;
            cpu_hold_q <= 1'b1;
            if (ld_len == 16'd0) begin
              state_q   <= DONE;
              ld_done_q <= 1'b1;
            end else begin
              state_q    <= LOAD;
              ld_ready_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            ptr_q <= ptr_q + 1'b1;
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q    <= DONE;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q    <= RUN;
          cpu_hold_q <= 1'b0;
        end
        default: begin
          state_q    <= RUN;
          ld_ready_q <= 1'b0;
          cpu_hold_q <= 1'b0;
        end
      endcase
    end
  end

  imem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .raddr_i (mem_i_ra[AW+1:2]),
    .rdata_o (rdata),
    .we_i    (beat),
    .waddr_i (ptr_q),
    .wdata_i (ld_data)
  );

  // Any set bit above the index field means the word index is past the array.
  assign misaligned   = |mem_i_ra[1:0];
  assign out_of_range = |mem_i_ra[31:AW+2];
  assign bad_fetch    = misaligned || out_of_range;

  assign i_fault  = (state_q == RUN) && bad_fetch;
  assign mem_i_rd = ((state_q == RUN) && !bad_fetch) ? rdata : NOP_WORD;

  assign ld_ready  = ld_ready_q;
  assign ld_done   = ld_done_q;
  assign cpu_hold  = cpu_hold_q;
  assign dbg_state = state_q;

  assign unused_base = &{1'b0, ld_base[31:AW+2], ld_base[1:0]};

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: loads, throttling, wrap, faults, mid-load reset.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_i_ra;
  logic [31:0] mem_i_rd;
  logic        i_fault;
  logic        ld_start;
  logic [31:0] ld_base;
  logic [15:0] ld_len;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        cpu_hold;
  imem_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];

  imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_i_ra  (mem_i_ra),
    .mem_i_rd  (mem_i_rd),
    .i_fault   (i_fault),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_len    (ld_len),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .cpu_hold  (cpu_hold),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one load; rst_after >= 0 asserts reset while the beat with that index is offered.
  task automatic do_load(input string tag, input logic [31:0] base, input logic [15:0] len,
                         input bit throttle, input int rst_after, input bit restart_mid);
    int beats = 0;
    int cyc = 0;
    int last_beat = 0;
    int hold_cyc = 0;
    bit done_seen = 0;
    bit tog = 1'b1;
    logic [AW-1:0] p;
    logic [31:0] d;
    p = base[AW+1:2];
    ld_start = 1'b1; ld_base = base; ld_len = len;
    tick();
    ld_start = 1'b0;
    while (!done_seen && cyc < 64) begin
      cyc++;
      if (cpu_hold) hold_cyc++;
      chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
      chk({tag, "_rd_nop"}, mem_i_rd, NOP);
      if (ld_done) begin
        done_seen = 1'b1;
        chk({tag, "_done_lat"}, cyc, last_beat + 1);
        chk({tag, "_beats"}, beats, {16'd0, len});
        chk({tag, "_ready_done"}, {31'd0, ld_ready}, 32'd0);
        // Junk offered while not ready must be dropped.
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_valid = 1'b0;
      end else begin
        chk({tag, "_ready"}, {31'd0, ld_ready}, 32'd1);
        chk({tag, "_fault0"}, {31'd0, i_fault}, 32'd0);
        d = $urandom;
        ld_valid = throttle ? tog : 1'b1;
        tog = ~tog;
        ld_data = d;
        if (restart_mid && beats == 1) begin
          ld_start = 1'b1; ld_base = 32'h0; ld_len = 16'd9;
        end else begin
          ld_start = 1'b0;
        end
        if (rst_after >= 0 && beats == rst_after) begin
          ld_valid = 1'b1;
          reset = 1'b1;
          #1;
          chk({tag, "_rst_ready"}, {31'd0, ld_ready}, 32'd0);
          chk({tag, "_rst_hold"}, {31'd0, cpu_hold}, 32'd0);
          chk({tag, "_rst_state"}, {30'd0, dbg_state}, {30'd0, RUN});
          tick();
          reset = 1'b0; ld_valid = 1'b0; ld_start = 1'b0;
          return;
        end
        if (ld_valid) begin
          model[p] = d;
          p = p + 1'b1;
          beats++;
          last_beat = cyc;
        end
        tick();
        ld_valid = 1'b0;
        ld_start = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
    chk({tag, "_hold_cycles"}, hold_cyc, cyc);
    if (!throttle) chk({tag, "_hold_n1"}, hold_cyc, {16'd0, len} + 1);
    chk({tag, "_run_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_run_state"}, {30'd0, dbg_state}, {30'd0, RUN});
  endtask

  task automatic readback(input string tag, input logic [31:0] base, input int n);
    logic [AW-1:0] idx;
    idx = base[AW+1:2];
    for (int i = 0; i < n; i++) exp_q.push_back(model[idx + AW'(i)]);
    for (int i = 0; i < n; i++) begin
      mem_i_ra = {20'd0, idx + AW'(i), 2'b00};
      #1;
      chk({tag, "_fault"}, {31'd0, i_fault}, 32'd0);
      chk({tag, "_data"}, mem_i_rd, exp_q.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1; mem_i_ra = 32'h0; ld_start = 1'b0; ld_base = 32'h0;
    ld_len = 16'd0; ld_valid = 1'b0; ld_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_done", {31'd0, ld_done}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, RUN});
    reset = 1'b0;
    tick();

    do_load("basic", 32'h100, 16'd3, 1'b0, -1, 1'b0);
    readback("basic_rb", 32'h100, 3);

    do_load("throttle", 32'h40, 16'd2, 1'b1, -1, 1'b0);
    readback("throttle_rb", 32'h40, 2);
    readback("basic_keep", 32'h100, 3);

    do_load("len0", 32'h300, 16'd0, 1'b0, -1, 1'b0);
    readback("len0_keep", 32'h40, 2);

    mem_i_ra = 32'h102; #1;
    chk("mis_fault", {31'd0, i_fault}, 32'd1);
    chk("mis_rd", mem_i_rd, NOP);
    mem_i_ra = DEPTH * 4; #1;
    chk("oob_fault", {31'd0, i_fault}, 32'd1);
    chk("oob_rd", mem_i_rd, NOP);
    mem_i_ra = 32'hFFFF_FFFC; #1;
    chk("oob_top_fault", {31'd0, i_fault}, 32'd1);

    do_load("wrap", (DEPTH - 1) * 4, 16'd2, 1'b0, -1, 1'b0);
    readback("wrap_rb", (DEPTH - 1) * 4, 2);

    do_load("pre", 32'h200, 16'd5, 1'b0, -1, 1'b0);
    do_load("midrst", 32'h200, 16'd5, 1'b0, 2, 1'b0);
    chk("midrst_state", {30'd0, dbg_state}, {30'd0, RUN});
    readback("midrst_rb", 32'h200, 5);

    do_load("restart", 32'h180, 16'd4, 1'b0, -1, 1'b1);
    readback("restart_rb", 32'h180, 4);
    readback("restart_keep", 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
